adc_result_fifo: RTL and testbench

// - Downstream of the oversampler: takes its async conversion-finished strobe and 16-bit result into the system clock domain.
// - Buffers results in a small first-word-fall-through FIFO with a valid/ready read port for the bus/host side.
// - Flags overflow, counts dropped samples and raises a fill-level threshold flag.

---
 rtl/adc_pkg.sv | 7 +
 rtl/adc_strobe_sync.sv | 27 ++
 rtl/adc_result_fifo.sv | 109 ++++++++++
 tb/tb_adc_result_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared ADC constants used by the oversampler, result FIFO and bus wrapper.
package adc_pkg;

    localparam int unsigned ADC_RESULT_W = 16;
    localparam int unsigned DROP_CNT_W   = 8;

endpackage

// File: rtl/adc_strobe_sync.sv
// Brings the asynchronous conversion-done strobe into clk and emits a one-cycle pulse per rising edge.
module adc_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_in,
    output logic event_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // All-ones reset: a strobe already high at reset release must not look like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign event_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_result_fifo.sv
// Captures oversampler results on the synchronized conversion strobe into a small FWFT FIFO
// with a valid/ready read port, sticky overflow, saturating drop counter and fill threshold.
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_RESULT_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned THRESH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_in,
    input  logic                      clear_in,
    input  logic                      conv_done_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      rd_valid_out,
    output logic [DATA_W-1:0]         rd_data_out,
    input  logic                      rd_ready_in,
    output logic [$clog2(DEPTH):0]    level_out,
    output logic                      overflow_out,
    output logic [DROP_CNT_W-1:0]     drop_cnt_out,
    output logic                      thresh_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    logic ev_c;
    logic empty_c;
    logic full_c;
    logic wr_req_c;
    logic pop_c;
    logic wr_ok_c;
    logic drop_c;

    adc_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .strobe_in (conv_done_in),
        .event_c   (ev_c)
    );

    // Level register is the only source of full/empty; clear overrides both ports.
    assign empty_c  = (level_q == '0);
    assign full_c   = (level_q == LVL_W'(DEPTH));
    assign wr_req_c = ev_c & en_in & ~clear_in;
    assign pop_c    = ~empty_c & rd_ready_in & ~clear_in;
    assign wr_ok_c  = wr_req_c & (~full_c | pop_c);
    assign drop_c   = wr_req_c & full_c & ~pop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_ok_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (drop_c) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers and level clear.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_c) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign rd_valid_out = ~empty_c;
    assign rd_data_out  = empty_c ? '0 : mem[rd_ptr_q];
    assign level_out    = level_q;
    assign overflow_out = overflow_q;
    assign drop_cnt_out = drop_cnt_q;
    assign thresh_out   = (level_q >= LVL_W'(THRESH));

endmodule

// File: tb/tb_adc_result_fifo.sv
// Scoreboard bench for adc_result_fifo: stimulus queues expected pops, a negedge monitor checks them.
module tb_adc_result_fifo;
    import adc_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en_in;
    logic                  clear_in;
    logic                  conv_done_in;
    logic [DW-1:0]         data_in;
    logic                  rd_valid_out;
    logic [DW-1:0]         rd_data_out;
    logic                  rd_ready_in;
    logic [LW-1:0]         level_out;
    logic                  overflow_out;
    logic [DROP_CNT_W-1:0] drop_cnt_out;
    logic                  thresh_out;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    adc_result_fifo #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2),
        .THRESH      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_in        (en_in),
        .clear_in     (clear_in),
        .conv_done_in (conv_done_in),
        .data_in      (data_in),
        .rd_valid_out (rd_valid_out),
        .rd_data_out  (rd_data_out),
        .rd_ready_in  (rd_ready_in),
        .level_out    (level_out),
        .overflow_out (overflow_out),
        .drop_cnt_out (drop_cnt_out),
        .thresh_out   (thresh_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] v);
        data_in      = v;
        conv_done_in = 1'b1;
        cyc(3);
        conv_done_in = 1'b0;
        cyc(3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready_in = 1'b1;
        while (level_out != '0 && n < 20) begin
            cyc(1);
            n++;
        end
        rd_ready_in = 1'b0;
        check("drain_level", 32'(level_out), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted head word must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && rd_valid_out && rd_ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", rd_data_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data_out !== e) begin
                    failures++;
                    $display("FAIL pop_data actual=%0h required=%0h", rd_data_out, e);
                end
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1; en_in = 1'b1; clear_in = 1'b0; conv_done_in = 1'b0;
        data_in = '0; rd_ready_in = 1'b0;
        cyc(1);
        check("rst_valid", 32'(rd_valid_out), 32'd0);
        check("rst_data", 32'(rd_data_out), 32'd0);
        check("rst_level", 32'(level_out), 32'd0);
        check("rst_thresh", 32'(thresh_out), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Single result and latency
        exp_q.push_back(16'hABC0);
        data_in = 16'hABC0; conv_done_in = 1'b1;
        cyc(2);
        check("lat_early", 32'(rd_valid_out), 32'd0);
        waited = 0;
        while (!rd_valid_out && waited < 2) begin
            cyc(1);
            waited++;
        end
        check("lat_valid", 32'(rd_valid_out), 32'd1);
        check("single_data", 32'(rd_data_out), 32'hABC0);
        check("single_level", 32'(level_out), 32'd1);
        conv_done_in = 1'b0;
        cyc(3);
        rd_ready_in = 1'b1;
        cyc(1);
        rd_ready_in = 1'b0;
        check("pop_valid", 32'(rd_valid_out), 32'd0);
        check("pop_data_zero", 32'(rd_data_out), 32'd0);
        check("pop_level", 32'(level_out), 32'd0);

        // Fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(DW'(i));
            strobe(DW'(i));
            check("fill_level", 32'(level_out), 32'(i));
            check("fill_thresh", 32'(thresh_out), (i >= 4) ? 32'd1 : 32'd0);
        end
        strobe(16'd9);
        check("ovf_level", 32'(level_out), 32'd8);
        check("ovf_flag", 32'(overflow_out), 32'd1);
        check("ovf_drop", 32'(drop_cnt_out), 32'd1);
        drain();
        check("ovf_sticky", 32'(overflow_out), 32'd1);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        check("clr_ovf", 32'(overflow_out), 32'd0);
        check("clr_drop", 32'(drop_cnt_out), 32'd0);

        // Full with simultaneous pop and write
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(DW'(i));
            strobe(DW'(i));
        end
        exp_q.push_back(16'd9);
        data_in = 16'd9; conv_done_in = 1'b1;
        cyc(2);
        rd_ready_in = 1'b1;
        cyc(1);
        rd_ready_in = 1'b0;
        check("fullpop_level", 32'(level_out), 32'd8);
        check("fullpop_ovf", 32'(overflow_out), 32'd0);
        check("fullpop_drop", 32'(drop_cnt_out), 32'd0);
        conv_done_in = 1'b0;
        cyc(3);
        drain();

        // Clear colliding with a write event at level 5 after an overflow
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(DW'(16'h50 + i));
            strobe(DW'(16'h50 + i));
        end
        strobe(16'h58);
        check("pre_clr_drop", 32'(drop_cnt_out), 32'd1);
        rd_ready_in = 1'b1;
        cyc(3);
        rd_ready_in = 1'b0;
        check("pre_clr_level", 32'(level_out), 32'd5);
        data_in = 16'h59; conv_done_in = 1'b1;
        cyc(2);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        exp_q.delete();
        check("clrw_level", 32'(level_out), 32'd0);
        check("clrw_ovf", 32'(overflow_out), 32'd0);
        check("clrw_drop", 32'(drop_cnt_out), 32'd0);
        check("clrw_valid", 32'(rd_valid_out), 32'd0);
        conv_done_in = 1'b0;
        cyc(3);

        // Event in flight across a clear is still stored
        exp_q.push_back(16'h66);
        data_in = 16'h66; conv_done_in = 1'b1;
        cyc(1);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        cyc(1);
        conv_done_in = 1'b0;
        cyc(3);
        check("inflight_level", 32'(level_out), 32'd1);
        drain();

        // Capture disabled
        en_in = 1'b0;
        for (int i = 0; i < 3; i++) strobe(DW'(16'hE1 + i));
        check("dis_level", 32'(level_out), 32'd0);
        check("dis_drop", 32'(drop_cnt_out), 32'd0);
        check("dis_valid", 32'(rd_valid_out), 32'd0);
        en_in = 1'b1;

        // Reset mid-operation with strobe held across release
        for (int i = 0; i < 8; i++) strobe(DW'(16'h80 + i));
        strobe(16'h88);
        check("pre_rst_drop", 32'(drop_cnt_out), 32'd1);
        data_in = 16'h77; conv_done_in = 1'b1; rst = 1'b1;
        cyc(1);
        exp_q.delete();
        check("mrst_valid", 32'(rd_valid_out), 32'd0);
        check("mrst_data", 32'(rd_data_out), 32'd0);
        check("mrst_level", 32'(level_out), 32'd0);
        check("mrst_ovf", 32'(overflow_out), 32'd0);
        check("mrst_drop", 32'(drop_cnt_out), 32'd0);
        check("mrst_thresh", 32'(thresh_out), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(6);
        check("held_level", 32'(level_out), 32'd0);
        check("held_valid", 32'(rd_valid_out), 32'd0);
        conv_done_in = 1'b0;
        cyc(3);
        exp_q.push_back(16'h1234);
        strobe(16'h1234);
        check("post_rst_level", 32'(level_out), 32'd1);
        check("post_rst_data", 32'(rd_data_out), 32'h1234);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
